// File: rtl/gain_pkg.sv
// Shared gain constants, types and the output saturation helper
// for the pedal-chain gain stages.
package gain_pkg;

  localparam int GAIN_W    = 16;
  localparam int GAIN_FRAC = 14;

  typedef logic [GAIN_W-1:0] gain_t;

  // Q2.14 presets; entries past the used levels stay at max gain
  localparam gain_t GAIN_TABLE [8] = '{
    16'h2000, 16'h4000, 16'h8000, 16'hC000,
    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF
  };

  // bit 32 = clip, bits [dw-1:0] = saturated sample
  function automatic logic [32:0] sat_shift(
    input logic signed [63:0] p,
    input int                 dw
  );
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic [32:0]        r;
    sh = p >>> GAIN_FRAC;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    r  = '0;
    if (sh > hi) begin
      r[31:0] = hi[31:0];
      r[32]   = 1'b1;
    end else if (sh < lo) begin
      r[31:0] = lo[31:0];
      r[32]   = 1'b1;
    end else begin
      r[31:0] = sh[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/gain_ramp_if.sv
// Frame bus between the codec sample port, the gain stage
// and the effect mux.
interface gain_ramp_if #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 2
);
  logic                       In_valid;
  logic [CHANNELS*DATA_W-1:0] Data_in;
  logic                       Out_valid;
  logic [CHANNELS*DATA_W-1:0] Data_out;
  logic                       Clip;

  modport master (
    output In_valid, Data_in,
    input  Out_valid, Data_out, Clip
  );

  modport slave (
    input  In_valid, Data_in,
    output Out_valid, Data_out, Clip
  );
endinterface

// File: rtl/button_debounce.sv
// Push-button synchroniser and debouncer; emits a one-cycle
// pulse on each debounced rising edge.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

  logic          sync0;
  logic          sync1;
  logic          prev;
  logic          state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
      state <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync0 <= button;
      sync1 <= sync0;
      prev  <= sync1;
      press <= 1'b0;
      if (sync1 != prev) begin
        cnt <= '0;
      end else if (cnt != LIMIT) begin
        cnt <= cnt + 1'b1;
      end else if (sync1 != state) begin
        state <= sync1;
        press <= sync1;
      end
    end
  end

endmodule

// File: rtl/gain_ramp.sv
// Multi-channel preset gain stage with per-frame ramping,
// mute and saturating two-stage multiply pipeline.
module gain_ramp
  import gain_pkg::*;
#(
  parameter int    DATA_W          = 16,
  parameter int    CHANNELS        = 2,
  parameter int    LEVELS          = 4,
  parameter gain_t RAMP_STEP       = 16'h0200,
  parameter int    DEBOUNCE_CYCLES = 500000
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      Button,
  input  logic                      Mute,
  gain_ramp_if.slave                io,
  output logic [$clog2(LEVELS)-1:0] volume_level,
  output gain_t                     Gain_cur
);

  localparam int LW = $clog2(LEVELS);
  localparam int PW = DATA_W + 17;

  logic                        press;
  logic [2:0]                  idx;
  gain_t                       target;
  gain_t                       gain_nxt;
  logic [16:0]                 up;
  logic [16:0]                 dn;
  logic                        v1;
  logic signed [PW-1:0]        prod [CHANNELS];
  logic [CHANNELS*DATA_W-1:0]  sat_data;
  logic                        sat_clip;
  logic [32:0]                 r;
  logic                        unused_bits;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (Clk),
    .rst_n (Reset_n),
    .button(Button),
    .press (press)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      volume_level <= LW'(1);
    end else if (press) begin
      volume_level <= (volume_level == LW'(LEVELS - 1))
                      ? '0 : volume_level + 1'b1;
    end
  end

  always_comb begin
    idx      = 3'(volume_level);
    target   = Mute ? '0 : GAIN_TABLE[idx];
    up       = {1'b0, target} - {1'b0, Gain_cur};
    dn       = {1'b0, Gain_cur} - {1'b0, target};
    gain_nxt = Gain_cur;
    unique case (1'b1)
      target > Gain_cur:
        gain_nxt = (up <= {1'b0, RAMP_STEP})
                   ? target : Gain_cur + RAMP_STEP;
      target < Gain_cur:
        gain_nxt = (dn <= {1'b0, RAMP_STEP})
                   ? target : Gain_cur - RAMP_STEP;
      default:
        gain_nxt = Gain_cur;
    endcase
  end

  // S1: the accepted frame is scaled by the pre-update gain
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v1       <= 1'b0;
      Gain_cur <= 16'h4000;
      for (int c = 0; c < CHANNELS; c++) prod[c] <= '0;
    end else begin
      v1 <= io.In_valid;
      if (io.In_valid) begin
        Gain_cur <= gain_nxt;
        for (int c = 0; c < CHANNELS; c++) begin
          prod[c] <= PW'($signed(io.Data_in[c*DATA_W +: DATA_W]))
                   * PW'($signed({1'b0, Gain_cur}));
        end
      end
    end
  end

  always_comb begin
    sat_data = '0;
    sat_clip = 1'b0;
    r        = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      r = sat_shift(64'(prod[c]), DATA_W);
      sat_data[c*DATA_W +: DATA_W] = r[DATA_W-1:0];
      sat_clip = sat_clip | r[32];
    end
  end

  assign unused_bits = ^r[31:DATA_W];

  // S2: outputs hold between frames
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      io.Out_valid <= 1'b0;
      io.Data_out  <= '0;
      io.Clip      <= 1'b0;
    end else begin
      io.Out_valid <= v1;
      io.Clip      <= v1 & sat_clip;
      if (v1) io.Data_out <= sat_data;
    end
  end

endmodule

// File: tb/tb_gain_ramp.sv
// Directed, table-driven bench for gain_ramp.
// Short debounce so presses take a few dozen cycles.
module tb_gain_ramp;

  logic        Clk;
  logic        Reset_n;
  logic        Button;
  logic        Mute;
  logic [1:0]  volume_level;
  logic [15:0] Gain_cur;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] d;
    logic [31:0] q;
    logic        c;
  } vec_t;

  vec_t unity  [4];
  vec_t triple [4];
  logic [31:0] bb [3];

  gain_ramp_if #(.DATA_W(16), .CHANNELS(2)) io ();

  gain_ramp #(
    .DATA_W(16),
    .CHANNELS(2),
    .LEVELS(4),
    .RAMP_STEP(16'h0200),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Button      (Button),
    .Mute        (Mute),
    .io          (io),
    .volume_level(volume_level),
    .Gain_cur    (Gain_cur)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic send(input  logic [31:0] d,
                      output logic [31:0] q,
                      output logic        c);
    logic ok;
    io.In_valid = 1'b1;
    io.Data_in  = d;
    @(posedge Clk); #1;
    io.In_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge Clk); #1;
      if (io.Out_valid) ok = 1'b1;
    end
    if (!ok) chk("out_valid_timeout", 32'(ok), 32'd1);
    q = io.Data_out;
    c = io.Clip;
  endtask

  task automatic frames(input int n, input logic [31:0] d);
    logic [31:0] q;
    logic        c;
    for (int i = 0; i < n; i++) send(d, q, c);
  endtask

  task automatic press_btn();
    Button = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    Button = 1'b0;
    repeat (20) @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [31:0] q;
    logic        c;
    logic [15:0] g;

    unity[0]  = '{32'h4537_1000, 32'h4537_1000, 1'b0};
    unity[1]  = '{32'h8000_7FFF, 32'h8000_7FFF, 1'b0};
    unity[2]  = '{32'hFFFF_0001, 32'hFFFF_0001, 1'b0};
    unity[3]  = '{32'h0000_C000, 32'h0000_C000, 1'b0};
    triple[0] = '{32'h4537_F000, 32'h7FFF_D000, 1'b1};
    triple[1] = '{32'h0100_FF00, 32'h0300_FD00, 1'b0};
    triple[2] = '{32'h2AAB_D555, 32'h7FFF_8000, 1'b1};
    triple[3] = '{32'h2AAA_D556, 32'h7FFE_8002, 1'b0};
    bb[0] = 32'h0001_0002;
    bb[1] = 32'h0003_0004;
    bb[2] = 32'hFFFE_FFFD;

    Reset_n     = 1'b0;
    Button      = 1'b0;
    Mute        = 1'b0;
    io.In_valid = 1'b0;
    io.Data_in  = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_out_valid", 32'(io.Out_valid), 32'd0);
    chk("rst_clip", 32'(io.Clip), 32'd0);
    chk("rst_data", io.Data_out, 32'd0);
    chk("rst_level", 32'(volume_level), 32'd1);
    chk("rst_gain", 32'(Gain_cur), 32'h4000);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    io.In_valid = 1'b1;
    io.Data_in  = 32'h4537_1000;
    @(posedge Clk); #1;
    io.In_valid = 1'b0;
    chk("lat_t1", 32'(io.Out_valid), 32'd0);
    @(posedge Clk); #1;
    chk("lat_t2", 32'(io.Out_valid), 32'd1);
    chk("first_data", io.Data_out, 32'h4537_1000);
    chk("first_clip", 32'(io.Clip), 32'd0);
    chk("first_level", 32'(volume_level), 32'd1);
    @(posedge Clk); #1;
    chk("drop_valid", 32'(io.Out_valid), 32'd0);
    chk("hold_data", io.Data_out, 32'h4537_1000);

    for (int i = 0; i < 4; i++) begin
      send(unity[i].d, q, c);
      chk($sformatf("unity%0d_data", i), q, unity[i].q);
      chk($sformatf("unity%0d_clip", i), 32'(c),
          32'(unity[i].c));
    end

    for (int i = 0; i < 5; i++) begin
      io.In_valid = (i < 3);
      io.Data_in  = (i < 3) ? bb[i] : 32'h0;
      @(posedge Clk); #1;
      if (i >= 1 && i <= 3) begin
        chk($sformatf("b2b%0d_valid", i), 32'(io.Out_valid), 32'd1);
        chk($sformatf("b2b%0d_data", i), io.Data_out, bb[i-1]);
      end
    end
    chk("b2b_end_valid", 32'(io.Out_valid), 32'd0);

    press_btn();
    chk("press1_level", 32'(volume_level), 32'd2);
    for (int k = 0; k < 32; k++) begin
      g = 16'h4000 + 16'(k * 16'h0200);
      send(32'h0100_0100, q, c);
      chk($sformatf("ramp%0d_data", k), q,
          {2{16'(g >> 6)}});
      chk($sformatf("ramp%0d_gain", k), 32'(Gain_cur),
          32'(g + 16'h0200));
    end
    send(32'h0100_0100, q, c);
    chk("ramp_end_data", q, 32'h0200_0200);

    for (int i = 0; i < 10; i++) begin
      Button = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      Button = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
    end
    repeat (20) @(posedge Clk);
    #1;
    chk("bounce_level", 32'(volume_level), 32'd2);

    press_btn();
    chk("press2_level", 32'(volume_level), 32'd3);
    frames(32, 32'h0);
    chk("lvl3_gain", 32'(Gain_cur), 32'hC000);
    for (int i = 0; i < 4; i++) begin
      send(triple[i].d, q, c);
      chk($sformatf("triple%0d_data", i), q, triple[i].q);
      chk($sformatf("triple%0d_clip", i), 32'(c),
          32'(triple[i].c));
    end

    press_btn();
    chk("press3_level", 32'(volume_level), 32'd0);
    frames(80, 32'h0);
    chk("lvl0_gain", 32'(Gain_cur), 32'h2000);
    send(32'h0001_FFFF, q, c);
    chk("half_floor", q, 32'h0000_FFFF);

    press_btn();
    chk("press4_level", 32'(volume_level), 32'd1);
    frames(16, 32'h0);
    chk("lvl1_gain", 32'(Gain_cur), 32'h4000);

    Mute = 1'b1;
    send(32'hFFFF_FFFF, q, c);
    chk("mute_first", q, 32'hFFFF_FFFF);
    frames(31, 32'hFFFF_FFFF);
    chk("mute_gain", 32'(Gain_cur), 32'h0);
    send(32'hFFFF_FFFF, q, c);
    chk("mute_data", q, 32'h0);
    chk("mute_clip", 32'(c), 32'd0);
    Mute = 1'b0;
    frames(32, 32'hFFFF_FFFF);
    chk("unmute_gain", 32'(Gain_cur), 32'h4000);

    press_btn();
    Mute = 1'b1;
    frames(5, 32'h7000_7000);
    chk("pre_rst_gain", 32'(Gain_cur), 32'h3600);
    io.In_valid = 1'b1;
    io.Data_in  = 32'h7000_7000;
    @(posedge Clk); #1;
    io.In_valid = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(io.Out_valid), 32'd0);
    chk("arst_data", io.Data_out, 32'h0);
    chk("arst_clip", 32'(io.Clip), 32'd0);
    chk("arst_level", 32'(volume_level), 32'd1);
    chk("arst_gain", 32'(Gain_cur), 32'h4000);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    Mute    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      chk($sformatf("post_rst%0d_valid", i),
          32'(io.Out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
